// File: rtl/bus_grant_ctrl_pkg.sv
// Shared definitions for the bus grant controller: FSM state encoding, default mux codes
// and the owner-index width helper.
package bus_grant_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam logic [7:0] IDLE_CODE_DEFAULT = 8'h00;
  localparam logic [7:0] ALU_BASE_CODE     = 8'h10;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_grant_ctrl_picker.sv
// Combinational rotating-priority pick: first requester at or after i_ptr, wrapping modulo N.
// Kept standalone so other arbiters can reuse it.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W:0]   w_sum  [N];
  logic [IDX_W-1:0] w_cand [N];
  logic [N-1:0]     w_hit;

  // Candidate gi is the requester gi places after the pointer.
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_cand
    assign w_sum[gi]  = {1'b0, i_ptr} + (IDX_W+1)'(gi);
    assign w_cand[gi] = (w_sum[gi] >= (IDX_W+1)'(N)) ?
                        IDX_W'(w_sum[gi] - (IDX_W+1)'(N)) : w_sum[gi][IDX_W-1:0];
    assign w_hit[gi]  = i_req[w_cand[gi]];
  end

  always_comb begin
    o_any = |w_hit;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_hit[k]) o_idx = w_cand[k];
    end
  end

endmodule

// File: rtl/bus_grant_ctrl.sv
// Round-robin bus arbiter driving the keyed mux chain: one tenure at a time, optional hold
// limit, and a single idle-key bubble between tenures so the key never jumps source to source.
module bus_grant_ctrl
  import bus_grant_ctrl_pkg::*;
#(
  parameter int         NUM_REQ   = 4,
  parameter logic [7:0] BASE_CODE = ALU_BASE_CODE,
  parameter logic [7:0] IDLE_CODE = IDLE_CODE_DEFAULT,
  parameter int         MAX_HOLD  = 16,
  localparam int        OWNER_W   = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [7:0]         mux_key,
  output logic [OWNER_W-1:0] owner,
  output logic               bus_busy,
  output logic               hold_tmo
);

  localparam int              CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $fatal(1, "bus_grant_ctrl: NUM_REQ must be 2..8");
  end
  if (MAX_HOLD < 0) begin : g_bad_max_hold
    $fatal(1, "bus_grant_ctrl: MAX_HOLD must be >= 0");
  end
  if (int'(BASE_CODE) + NUM_REQ - 1 > 255) begin : g_bad_base
    $fatal(1, "bus_grant_ctrl: BASE_CODE+NUM_REQ-1 exceeds 8'hFF");
  end
  if (int'(IDLE_CODE) >= int'(BASE_CODE) &&
      int'(IDLE_CODE) <= int'(BASE_CODE) + NUM_REQ - 1) begin : g_bad_idle
    $fatal(1, "bus_grant_ctrl: IDLE_CODE collides with a requester code");
  end

  state_t             r_state, w_state_next;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
  logic [7:0]         r_key, w_key_next;
  logic [OWNER_W-1:0] r_owner, w_owner_next;
  logic [OWNER_W-1:0] r_rr_ptr, w_rr_ptr_next;
  logic               r_busy, w_busy_next;
  logic               r_tmo, w_tmo_next;
  logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt_next;

  logic               w_pick_any;
  logic [OWNER_W-1:0] w_pick_idx;
  logic               w_owner_req;
  logic               w_expire;
  logic               w_exit;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (OWNER_W)
  ) u_picker (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_any (w_pick_any),
    .o_idx (w_pick_idx)
  );

  assign w_owner_req = req[r_owner];
  assign w_expire    = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
  assign w_exit      = !w_owner_req || w_expire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_key      <= IDLE_CODE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_busy     <= 1'b0;
      r_tmo      <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_gnt      <= w_gnt_next;
      r_key      <= w_key_next;
      r_owner    <= w_owner_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_busy     <= w_busy_next;
      r_tmo      <= w_tmo_next;
      r_hold_cnt <= w_hold_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  w_state_next = w_pick_any ? ST_GRANT : ST_IDLE;
      ST_GRANT: w_state_next = w_exit ? ST_TURN : ST_GRANT;
      ST_TURN:  w_state_next = w_pick_any ? ST_GRANT : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_next      = r_gnt;
    w_key_next      = r_key;
    w_owner_next    = r_owner;
    w_rr_ptr_next   = r_rr_ptr;
    w_busy_next     = r_busy;
    w_tmo_next      = 1'b0;
    w_hold_cnt_next = r_hold_cnt;
    case (r_state)
      ST_IDLE, ST_TURN: begin
        if (w_pick_any) begin
          w_gnt_next      = NUM_REQ'(1) << w_pick_idx;
          w_key_next      = BASE_CODE + 8'(w_pick_idx);
          w_owner_next    = w_pick_idx;
          w_busy_next     = 1'b1;
          w_hold_cnt_next = '0;
        end else begin
          w_gnt_next  = '0;
          w_key_next  = IDLE_CODE;
          w_busy_next = 1'b0;
        end
      end
      ST_GRANT: begin
        if (w_exit) begin
          w_gnt_next    = '0;
          w_key_next    = IDLE_CODE;
          w_busy_next   = 1'b0;
          w_rr_ptr_next = (r_owner == OWNER_W'(NUM_REQ - 1)) ? '0 : r_owner + OWNER_W'(1);
          // A simultaneous release counts as a normal end of tenure.
          w_tmo_next    = w_expire && w_owner_req;
        end else if (r_hold_cnt != '1) begin
          w_hold_cnt_next = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_gnt_next  = '0;
        w_key_next  = IDLE_CODE;
        w_busy_next = 1'b0;
      end
    endcase
  end

  assign gnt      = r_gnt;
  assign mux_key  = r_key;
  assign owner    = r_owner;
  assign bus_busy = r_busy;
  assign hold_tmo = r_tmo;

endmodule
